// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: decodes the ID instruction and carries the control word
// through the ID/EX, EX/MEM and MEM/WB stages. Also produces the stall, forwarding and redirect controls.
module pipe_ctrl_unit #(
  parameter int FWD_EN   = 1,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         id_instr_i,
  input  logic                id_vld_i,
  input  logic                br_less_i,
  input  logic                br_equal_i,
  output logic                pc_en_o,
  output logic                ifid_en_o,
  output logic                ifid_flush_o,
  output logic                pc_sel_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic                ex_op_a_sel_o,
  output logic                ex_op_b_sel_o,
  output logic                ex_bl_unsigned_o,
  output logic [1:0]          fwd_a_sel_o,
  output logic [1:0]          fwd_b_sel_o,
  output logic                mem_wren_o,
  output logic [2:0]          mem_funct3_o,
  output logic                wb_rd_wren_o,
  output logic [1:0]          wb_sel_o,
  output logic [4:0]          wb_rd_addr_o,
  output logic                insn_vld_o,
  output logic                illegal_o
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'd0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(4'd1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(4'd2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4'd3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4'd4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4'd5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(4'd6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(4'd7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(4'd8);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4'd9);
  localparam logic [ALU_OP_W-1:0] ALU_PASB = ALU_OP_W'(4'd10);

  typedef struct packed {
    logic                rd_wren;
    logic                op_a_sel;
    logic                op_b_sel;
    logic                bl_unsigned;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_wren;
    logic [1:0]          wb_sel;
    logic                is_load;
    logic                is_branch;
    logic                is_jump;
    logic [2:0]          funct3;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                use_rs1;
    logic                use_rs2;
    logic                legal;
  } ctrl_t;

  ctrl_t      raw_s, dec_s, ex_r, mem_r, wb_r;
  logic       ex_vld_r, mem_vld_r, wb_vld_r;
  logic [6:0] op_s;
  logic [2:0] f3_s;
  logic       f7b5_s;
  logic       taken_s, hazard_s, stall_s, bubble_s;
  logic       load_use_s, raw_hit_s;
  logic [1:0] fwd_a_s, fwd_b_s;
  logic       unused_s;

  function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // True when a valid register-writing stage targets a non-zero rs.
  function automatic logic wr_hit(input logic vld, input ctrl_t c, input logic [4:0] rs);
    return vld && c.rd_wren && (c.rd != 5'd0) && (c.rd == rs);
  endfunction

  function automatic logic id_hit(input logic vld, input ctrl_t c, input ctrl_t id);
    return (id.use_rs1 && wr_hit(vld, c, id.rs1)) || (id.use_rs2 && wr_hit(vld, c, id.rs2));
  endfunction

  assign op_s   = id_instr_i[6:0];
  assign f3_s   = id_instr_i[14:12];
  assign f7b5_s = id_instr_i[30];

  // Decode the ID instruction into a raw control word plus legality.
  always_comb begin
    raw_s        = '0;
    raw_s.funct3 = f3_s;
    raw_s.rd     = id_instr_i[11:7];
    raw_s.rs1    = id_instr_i[19:15];
    raw_s.rs2    = id_instr_i[24:20];
    case (op_s)
      OP_LUI: begin
        raw_s.legal = 1'b1; raw_s.rd_wren = 1'b1; raw_s.op_b_sel = 1'b1; raw_s.alu_op = ALU_PASB;
      end
      OP_AUIPC: begin
        raw_s.legal = 1'b1; raw_s.rd_wren = 1'b1; raw_s.op_a_sel = 1'b1; raw_s.op_b_sel = 1'b1;
      end
      OP_JAL: begin
        raw_s.legal = 1'b1; raw_s.rd_wren = 1'b1; raw_s.op_a_sel = 1'b1; raw_s.op_b_sel = 1'b1;
        raw_s.wb_sel = 2'd2; raw_s.is_jump = 1'b1;
      end
      OP_JALR: begin
        raw_s.legal = (f3_s == 3'b000); raw_s.rd_wren = 1'b1; raw_s.op_b_sel = 1'b1;
        raw_s.wb_sel = 2'd2; raw_s.is_jump = 1'b1; raw_s.use_rs1 = 1'b1;
      end
      OP_BR: begin
        raw_s.legal = (f3_s[2:1] != 2'b01); raw_s.op_a_sel = 1'b1; raw_s.op_b_sel = 1'b1;
        raw_s.is_branch = 1'b1; raw_s.bl_unsigned = f3_s[1];
        raw_s.use_rs1 = 1'b1; raw_s.use_rs2 = 1'b1;
      end
      OP_LOAD: begin
        raw_s.legal = (f3_s != 3'b011) && (f3_s[2:1] != 2'b11);
        raw_s.rd_wren = 1'b1; raw_s.op_b_sel = 1'b1; raw_s.wb_sel = 2'd1;
        raw_s.is_load = 1'b1; raw_s.use_rs1 = 1'b1;
      end
      OP_STORE: begin
        raw_s.legal = (f3_s[2] == 1'b0) && (f3_s != 3'b011); raw_s.op_b_sel = 1'b1;
        raw_s.mem_wren = 1'b1; raw_s.use_rs1 = 1'b1; raw_s.use_rs2 = 1'b1;
      end
      OP_IMM: begin
        raw_s.legal = 1'b1; raw_s.rd_wren = 1'b1; raw_s.op_b_sel = 1'b1; raw_s.use_rs1 = 1'b1;
        raw_s.alu_op = alu_fn(f3_s, f7b5_s && (f3_s == 3'b101));
      end
      OP_REG: begin
        raw_s.legal = 1'b1; raw_s.rd_wren = 1'b1; raw_s.use_rs1 = 1'b1; raw_s.use_rs2 = 1'b1;
        raw_s.alu_op = alu_fn(f3_s, f7b5_s);
      end
      default: raw_s.legal = 1'b0;
    endcase
  end

  // An undecodable instruction travels with an all-zero control word.
  assign dec_s = raw_s.legal ? raw_s : '0;

  // Branch resolution and hazard detection for the current stage contents.
  always_comb begin
    taken_s = 1'b0;
    if (ex_vld_r && ex_r.is_jump) begin
      taken_s = 1'b1;
    end else if (ex_vld_r && ex_r.is_branch) begin
      case (ex_r.funct3)
        3'b000:  taken_s = br_equal_i;
        3'b001:  taken_s = ~br_equal_i;
        3'b100,
        3'b110:  taken_s = br_less_i;
        3'b101,
        3'b111:  taken_s = ~br_less_i;
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
    load_use_s = ex_r.is_load && id_hit(ex_vld_r, ex_r, dec_s);
    raw_hit_s  = id_hit(ex_vld_r, ex_r, dec_s) || id_hit(mem_vld_r, mem_r, dec_s) ||
                 id_hit(wb_vld_r, wb_r, dec_s);
    if (FWD_EN != 0) begin
      hazard_s = id_vld_i && load_use_s;
    end else begin
      hazard_s = id_vld_i && raw_hit_s;
    end
    stall_s  = hazard_s && !taken_s;
    bubble_s = taken_s || stall_s || !id_vld_i;
  end

  // Forwarding select for the EX operands; EX/MEM wins over MEM/WB, loads in MEM cannot forward.
  always_comb begin
    fwd_a_s = 2'd0;
    fwd_b_s = 2'd0;
    if ((FWD_EN != 0) && ex_vld_r) begin
      if (wr_hit(mem_vld_r, mem_r, ex_r.rs1) && !mem_r.is_load) begin
        fwd_a_s = 2'd1;
      end else if (wr_hit(wb_vld_r, wb_r, ex_r.rs1)) begin
        fwd_a_s = 2'd2;
      end else begin
        fwd_a_s = 2'd0;
      end
      if (wr_hit(mem_vld_r, mem_r, ex_r.rs2) && !mem_r.is_load) begin
        fwd_b_s = 2'd1;
      end else if (wr_hit(wb_vld_r, wb_r, ex_r.rs2)) begin
        fwd_b_s = 2'd2;
      end else begin
        fwd_b_s = 2'd0;
      end
    end else begin
      fwd_a_s = 2'd0;
      fwd_b_s = 2'd0;
    end
  end

  // Stage registers: ID/EX loads the decoded word or a bubble, later stages shift unconditionally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_r      <= '0;
      mem_r     <= '0;
      wb_r      <= '0;
      ex_vld_r  <= 1'b0;
      mem_vld_r <= 1'b0;
      wb_vld_r  <= 1'b0;
    end else begin
      if (bubble_s) begin
        ex_r     <= '0;
        ex_vld_r <= 1'b0;
      end else begin
        ex_r     <= dec_s;
        ex_vld_r <= 1'b1;
      end
      mem_r     <= ex_r;
      mem_vld_r <= ex_vld_r;
      wb_r      <= mem_r;
      wb_vld_r  <= mem_vld_r;
    end
  end

  // Output drive; every stage control is qualified by that stage's valid bit.
  always_comb begin
    pc_en_o          = ~stall_s;
    ifid_en_o        = ~stall_s;
    ifid_flush_o     = taken_s;
    pc_sel_o         = taken_s;
    ex_alu_op_o      = ex_vld_r ? ex_r.alu_op : '0;
    ex_op_a_sel_o    = ex_vld_r & ex_r.op_a_sel;
    ex_op_b_sel_o    = ex_vld_r & ex_r.op_b_sel;
    ex_bl_unsigned_o = ex_vld_r & ex_r.bl_unsigned;
    fwd_a_sel_o      = fwd_a_s;
    fwd_b_sel_o      = fwd_b_s;
    mem_wren_o       = mem_vld_r & mem_r.mem_wren;
    mem_funct3_o     = mem_vld_r ? mem_r.funct3 : 3'd0;
    wb_rd_wren_o     = wb_vld_r & wb_r.rd_wren;
    wb_sel_o         = wb_vld_r ? wb_r.wb_sel : 2'd0;
    wb_rd_addr_o     = wb_vld_r ? wb_r.rd : 5'd0;
    insn_vld_o       = wb_vld_r & wb_r.legal;
    illegal_o        = wb_vld_r & ~wb_r.legal;
  end

  assign unused_s = ^{id_instr_i[31], id_instr_i[29:25], mem_r, wb_r};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit; one instance with forwarding,
// one without, both fed the same ID stream.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        vld, br_less, br_equal;

  logic       pc_en1, ifid_en1, flush1, pc_sel1, op_a1, op_b1, blu1, mwr1, wwr1, ivld1, ill1;
  logic [3:0] alu1;
  logic [1:0] fa1, fb1, wsel1;
  logic [2:0] mf3_1;
  logic [4:0] wrd1;

  logic       pc_en0, ifid_en0, flush0, pc_sel0, op_a0, op_b0, blu0, mwr0, wwr0, ivld0, ill0;
  logic [3:0] alu0;
  logic [1:0] fa0, fb0, wsel0;
  logic [2:0] mf3_0;
  logic [4:0] wrd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.FWD_EN(1), .ALU_OP_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .id_instr_i(instr), .id_vld_i(vld),
    .br_less_i(br_less), .br_equal_i(br_equal),
    .pc_en_o(pc_en1), .ifid_en_o(ifid_en1), .ifid_flush_o(flush1), .pc_sel_o(pc_sel1),
    .ex_alu_op_o(alu1), .ex_op_a_sel_o(op_a1), .ex_op_b_sel_o(op_b1), .ex_bl_unsigned_o(blu1),
    .fwd_a_sel_o(fa1), .fwd_b_sel_o(fb1), .mem_wren_o(mwr1), .mem_funct3_o(mf3_1),
    .wb_rd_wren_o(wwr1), .wb_sel_o(wsel1), .wb_rd_addr_o(wrd1),
    .insn_vld_o(ivld1), .illegal_o(ill1)
  );

  pipe_ctrl_unit #(.FWD_EN(0), .ALU_OP_W(4)) u0 (
    .clk_i(clk), .rst_i(rst), .id_instr_i(instr), .id_vld_i(vld),
    .br_less_i(br_less), .br_equal_i(br_equal),
    .pc_en_o(pc_en0), .ifid_en_o(ifid_en0), .ifid_flush_o(flush0), .pc_sel_o(pc_sel0),
    .ex_alu_op_o(alu0), .ex_op_a_sel_o(op_a0), .ex_op_b_sel_o(op_b0), .ex_bl_unsigned_o(blu0),
    .fwd_a_sel_o(fa0), .fwd_b_sel_o(fb0), .mem_wren_o(mwr0), .mem_funct3_o(mf3_0),
    .wb_rd_wren_o(wwr0), .wb_sel_o(wsel0), .wb_rd_addr_o(wrd0),
    .insn_vld_o(ivld0), .illegal_o(ill0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vld = 1'b0; br_less = 1'b0; br_equal = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {7'b0000000, rs2, rs1, f3, 5'b01000, 7'b1100011};
  endfunction

  initial begin
    rst = 1'b1; vld = 1'b1; br_less = 1'b0; br_equal = 1'b0;
    instr = enc_r(7'd0, 5'd3, 5'd2, 3'd0, 5'd1);
    // reset held for two edges, then the ADD retires three edges after release
    tick(); #1;
    chk("rst_pc_en", pc_en1, 1); chk("rst_ifid_en", ifid_en1, 1);
    chk("rst_flush", flush1, 0); chk("rst_pc_sel", pc_sel1, 0);
    chk("rst_alu", alu1, 0); chk("rst_fwd", {fa1, fb1}, 0);
    chk("rst_mwr", mwr1, 0); chk("rst_wwr", wwr1, 0);
    chk("rst_ivld", ivld1, 0); chk("rst_ill", ill1, 0);
    tick(); rst = 1'b0; #1;
    chk("rel_ivld0", ivld1, 0);
    tick(); chk("rel_ivld1", ivld1, 0); chk("rel_ex_alu", alu1, 0);
    tick(); chk("rel_ivld2", ivld1, 0);
    tick(); chk("rel_ivld3", ivld1, 1); chk("rel_wrd", wrd1, 1); chk("rel_wwr", wwr1, 1);

    // ALU forwarding: ADD x5,x1,x2 then SUB x6,x5,x5
    drain();
    vld = 1'b1; instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd5); #1;
    chk("fw_pc_en0", pc_en1, 1);
    tick(); instr = enc_r(7'b0100000, 5'd5, 5'd5, 3'd0, 5'd6); #1;
    chk("fw_pc_en1", pc_en1, 1); chk("fw_add_alu", alu1, 0);
    tick(); vld = 1'b0; #1;
    chk("fw_a", fa1, 1); chk("fw_b", fb1, 1); chk("fw_sub_alu", alu1, 1);

    // load-use: LW x7,0(x1) then ADD x8,x7,x0
    drain();
    vld = 1'b1; instr = enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011); #1;
    chk("lu_pc_en0", pc_en1, 1);
    tick(); instr = enc_r(7'd0, 5'd0, 5'd7, 3'd0, 5'd8); #1;
    chk("lu_pc_en1", pc_en1, 0); chk("lu_ifid_en1", ifid_en1, 0);
    chk("lu_ld_b_sel", op_b1, 1);
    tick(); #1;
    chk("lu_pc_en2", pc_en1, 1); chk("lu_ifid_en2", ifid_en1, 1); chk("lu_mf3", mf3_1, 2);
    tick(); vld = 1'b0; #1;
    chk("lu_fwd_a", fa1, 2); chk("lu_fwd_b", fb1, 0); chk("lu_wsel", wsel1, 1);

    // x0 never forwards: ADDI x0,x0,1 then ADD x9,x0,x0
    drain();
    vld = 1'b1; instr = enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'b0010011); #1;
    tick(); instr = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd9); #1;
    chk("x0_pc_en", pc_en1, 1);
    tick(); vld = 1'b0; #1;
    chk("x0_fwd_a", fa1, 0); chk("x0_fwd_b", fb1, 0);

    // taken BEQ: the younger ADD in ID and the flushed fetch must never write
    drain();
    vld = 1'b1; instr = enc_b(5'd2, 5'd1, 3'b000); #1;
    tick(); instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd10); br_equal = 1'b1; #1;
    chk("beq_pc_sel", pc_sel1, 1); chk("beq_flush", flush1, 1); chk("beq_pc_en", pc_en1, 1);
    chk("beq_unsigned", blu1, 0);
    tick(); vld = 1'b0; br_equal = 1'b0; #1;
    chk("beq_pc_sel_off", pc_sel1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("beq_wwr", wwr1, 0); chk("beq_mwr", mwr1, 0);
      chk("beq_ivld", ivld1, (i == 1) ? 1 : 0);
      tick();
    end

    // taken BLTU, then not-taken BNE with equal operands
    drain();
    vld = 1'b1; instr = enc_b(5'd4, 5'd3, 3'b110); #1;
    tick(); instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd12); br_less = 1'b1; #1;
    chk("bltu_unsigned", blu1, 1); chk("bltu_pc_sel", pc_sel1, 1); chk("bltu_flush", flush1, 1);
    tick(); vld = 1'b0; br_less = 1'b0; #1;
    repeat (2) begin
      tick(); chk("bltu_wwr", wwr1, 0);
    end
    drain();
    vld = 1'b1; instr = enc_b(5'd4, 5'd3, 3'b001); #1;
    tick(); vld = 1'b0; br_equal = 1'b1; #1;
    chk("bne_pc_sel", pc_sel1, 0); chk("bne_flush", flush1, 0);

    // no forwarding: ADD x5,x1,x2 then ADD x6,x5,x1 stalls three cycles
    drain();
    vld = 1'b1; instr = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd5); #1;
    chk("nf_pc_en0", pc_en0, 1);
    tick(); instr = enc_r(7'd0, 5'd1, 5'd5, 3'd0, 5'd6); #1;
    chk("nf_stall1", pc_en0, 0); chk("nf_ifid1", ifid_en0, 0);
    tick(); chk("nf_stall2", pc_en0, 0);
    tick(); chk("nf_stall3", pc_en0, 0);
    tick(); chk("nf_go", pc_en0, 1);
    tick(); vld = 1'b0; #1;
    chk("nf_fwd_a", fa0, 0); chk("nf_fwd_b", fb0, 0);

    // illegal opcode 7'b1111111
    drain();
    vld = 1'b1; instr = 32'hFFFF_FFFF; #1;
    tick(); vld = 1'b0; #1;
    chk("ill_alu", alu0, 0); chk("ill_b_sel", op_b0, 0);
    tick(); chk("ill_mwr", mwr0, 0);
    tick();
    chk("ill_flag0", ill0, 1); chk("ill_ivld0", ivld0, 0); chk("ill_wwr0", wwr0, 0);
    chk("ill_flag1", ill1, 1); chk("ill_wwr1", wwr1, 0);

    // reset mid-stream discards in-flight instructions
    drain();
    vld = 1'b1; instr = enc_r(7'd0, 5'd3, 5'd2, 3'd0, 5'd1);
    repeat (3) tick();
    chk("mid_wwr_before", wwr1, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; vld = 1'b0; #1;
    chk("mid_wwr", wwr1, 0); chk("mid_ivld", ivld1, 0); chk("mid_alu", alu1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It decodes the ID-stage instruction into a control word and carries it through registered ID/EX, EX/MEM and MEM/WB stages with per-stage valid bits. It also performs hazard detection (load-use or full-RAW stall), forwarding selection and branch/jump redirect with flush. It replaces the single-cycle control decoder.

## Interface
- `FWD_EN`, default 1: 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any RAW.
- `ALU_OP_W`, default 4: width of the ALU opcode.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `id_instr_i`  in  32  instruction in ID.
- `id_vld_i`  in  1  ID instruction valid (IF/ID register holds a real fetch).
- `br_less_i`, `br_equal_i`  in  1 each  EX-stage comparator results for the instruction in EX.
- `pc_en_o`  out  1  PC register enable.
- `ifid_en_o`  out  1  IF/ID register enable.
- `ifid_flush_o`  out  1  clear the IF/ID valid bit.
- `pc_sel_o`  out  1  0 = PC+4, 1 = EX ALU result (redirect).
- `ex_alu_op_o`  out  ALU_OP_W  ALU operation in EX.
- `ex_op_a_sel_o`, `ex_op_b_sel_o`, `ex_bl_unsigned_o`  out  1 each  EX operand and compare controls.
- `fwd_a_sel_o`, `fwd_b_sel_o`  out  2 each  0 = regfile, 1 = EX/MEM ALU result, 2 = WB data.
- `mem_wren_o`  out  1  LSU write.
- `mem_funct3_o`  out  3  LSU access size/sign.
- `wb_rd_wren_o`  out  1  regfile write.
- `wb_sel_o`  out  2  0 = ALU, 1 = load, 2 = PC+4.
- `wb_rd_addr_o`  out  5  destination register.
- `insn_vld_o`  out  1  valid, legal instruction retiring in WB.
- `illegal_o`  out  1  valid but undecodable instruction retiring in WB.

## Operation
- **ALU opcode encoding.**
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI).
  - Opcodes and funct3/funct7[5] decode as in RV32I base.
- **Decode (ID, combinational).**
  - Produces: rd_wren, op_a_sel, op_b_sel, alu_op, mem_wren, wb_sel, is_load, is_branch, is_jump, funct3, rd, rs1, rs2, legal.
  - Unknown opcode, or unknown funct3 in R/I/B: control word all-zero, legal = 0.
- **Register-use flags.**
  - rs1 used by R, I-calc, load, S, B, JALR.
  - rs2 used by R, S, B.
  - LUI, AUIPC and JAL use neither.
- **Pipeline registers.**
  - Each stage holds a control word and a `vld` bit.
  - All outputs are gated by the owning stage's `vld`: `mem_wren_o`, `wb_rd_wren_o` and `pc_sel_o` are 0 when that stage is invalid.
- **Branch resolution (EX).**
  - Taken = valid B-type whose funct3 condition is met on `br_equal_i`/`br_less_i` (BLTU/BGEU: `ex_bl_unsigned_o` = 1), or valid JAL/JALR.
  - Taken: `pc_sel_o` = 1, `ifid_flush_o` = 1, and a bubble is loaded into ID/EX at the next edge.
  - Resolution penalty: 2 cycles.
- **Forwarding (FWD_EN = 1).**
  - For each of rs1 (a) and rs2 (b) of the EX instruction:
    - select 1 if EX/MEM is valid, rd_wren, not a load, rd ≠ 0 and rd = rs;
    - else select 2 if MEM/WB is valid, rd_wren, rd ≠ 0 and rd = rs;
    - else select 0.
  - EX/MEM has priority over MEM/WB.
- **Load-use stall (FWD_EN = 1).**
  - Condition: EX is a valid load, rd ≠ 0, and rd matches a used rs of a valid ID instruction.
  - Action: `pc_en_o` = 0, `ifid_en_o` = 0, bubble into ID/EX. Penalty 1 cycle.
- **RAW stall (FWD_EN = 0).**
  - Condition: a used ID rs (≠ 0) matches the rd of any valid rd_wren instruction in EX, MEM or WB.
  - `fwd_*_sel_o` is held at 0.
- **Priority.**
  - Redirect overrides stall: `pc_en_o` = 1, `ifid_en_o` = 1, flush, bubble.
- **Illegal instructions.**
  - Flow down the pipeline with `vld` = 1 and a zero control word.
  - At WB they assert `illegal_o`, with `insn_vld_o` = 0.
  - They never write the regfile or memory.

## Timing
- **Reset.** A synchronous `rst_i` on the clock edge clears all stage `vld` bits and control words. Outputs one cycle later:
  - `pc_en_o` = 1, `ifid_en_o` = 1, `ifid_flush_o` = 0, `pc_sel_o` = 0;
  - all EX/MEM/WB controls = 0, `fwd_*` = 0, `insn_vld_o` = 0, `illegal_o` = 0.
- **Reset mid-operation.** Discards every in-flight instruction. No write enable is asserted in the cycle after the reset edge.
- **Pipeline timing.**
  - Decode to EX outputs: 1 cycle.
  - MEM outputs: 2 cycles.
  - WB outputs: 3 cycles after ID.
- **Combinational outputs.** Stall, redirect and forward outputs are combinational from current stage state and `id_instr_i`/`br_*_i`, all within the same cycle.
- **Stall hold.** During a stall, IF/ID is held. EX/MEM and MEM/WB continue advancing.
- **Load-use plus taken branch.** A load-use stall and a taken branch in EX cannot both be true, because EX holds one instruction. No special case is needed.
- **Invalid ID.** `id_vld_i` = 0 inserts a bubble and never causes a stall.

## Test plan
- **Reset.** Assert `rst_i` for 2 cycles with `id_instr_i` = ADD x1,x2,x3 (valid) -> all outputs at reset values; first `insn_vld_o` appears 3 cycles after release.
- **ALU forwarding (FWD_EN = 1).** ADD x5,x1,x2 followed by SUB x6,x5,x5 -> in SUB's EX cycle `fwd_a_sel_o` = `fwd_b_sel_o` = 1 and `ex_alu_op_o` = 1; no stall.
- **Load-use stall.** LW x7,0(x1) followed by ADD x8,x7,x0 -> exactly one cycle with `pc_en_o` = 0 and `ifid_en_o` = 0, then `fwd_a_sel_o` = 2.
- **x0 is never forwarded.** ADDI x0,x0,1 followed by ADD x9,x0,x0 -> `fwd_a_sel_o` = `fwd_b_sel_o` = 0 and no stall.
- **Taken branch.** BEQ with `br_equal_i` = 1 in EX -> `pc_sel_o` = 1 and `ifid_flush_o` = 1; the next two younger instructions never assert `wb_rd_wren_o` or `mem_wren_o`. Repeat with BLTU and check `ex_bl_unsigned_o` = 1.
- **FWD_EN = 0 and illegal.**
  - ADD x5,.. followed by ADD x6,x5,.. -> 3 stall cycles.
  - Opcode 7'b1111111 -> `illegal_o` = 1 at WB, no write enables.
